// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus decoded-instruction handshake and redirect.
// master = fetch unit side, slave = memory/decode/branch-resolution side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [59:0]       mem_rdata;

    logic              inst_valid;
    logic              dec_ready;
    logic [3:0]        opcode;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [43:0]       imm;
    logic [ADDR_W-1:0] inst_pc;

    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output mem_req, mem_addr,
        input  mem_valid, mem_rdata,
        output inst_valid, opcode, rd, rs1, rs2, imm, inst_pc,
        input  dec_ready,
        input  redirect_en, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_valid, mem_rdata,
        input  inst_valid, opcode, rd, rs1, rs2, imm, inst_pc,
        output dec_ready,
        output redirect_en, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: holds the PC, issues word reads, presents split instruction fields to decode.
// Latency: inst_valid on the edge that samples mem_valid; one instruction per 2 cycles at best.
// Backpressure: held instruction stays until dec_ready (or a redirect); no fetch is issued while holding.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   bus
);

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [43:0] imm;
    } inst_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    inst_t             inst_q, inst_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              vld_q, vld_d;
    logic              drop_q, drop_d;

    logic [ADDR_W-1:0] addr_inc;
    assign addr_inc = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            inst_q  <= '0;
            ipc_q   <= RESET_PC;
            vld_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            vld_q   <= vld_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        vld_d   = vld_q;
        drop_d  = drop_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                req_d   = 1'b1;
                if (bus.redirect_en) begin
                    pc_d   = bus.redirect_pc;
                    addr_d = bus.redirect_pc;
                end else begin
                    addr_d = pc_q;
                end
            end

            ST_REQ: begin
                if (bus.redirect_en) begin
                    pc_d = bus.redirect_pc;
                    if (bus.mem_valid) begin
                        // Response retires the old request, so the new target can go out now.
                        addr_d = bus.redirect_pc;
                        drop_d = 1'b0;
                    end else begin
                        // Address must stay put while a request is in flight; kill its data later.
                        drop_d = 1'b1;
                    end
                end else if (bus.mem_valid) begin
                    if (drop_q) begin
                        drop_d = 1'b0;
                        addr_d = pc_q;
                    end else begin
                        inst_d  = bus.mem_rdata;
                        ipc_d   = addr_q;
                        vld_d   = 1'b1;
                        pc_d    = addr_inc;
                        req_d   = 1'b0;
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (bus.redirect_en) begin
                    vld_d   = 1'b0;
                    pc_d    = bus.redirect_pc;
                    addr_d  = bus.redirect_pc;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else if (bus.dec_ready) begin
                    vld_d   = 1'b0;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                vld_d   = 1'b0;
                drop_d  = 1'b0;
            end
        endcase
    end

    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = addr_q;
    assign bus.inst_valid = vld_q;
    assign bus.opcode     = inst_q.opcode;
    assign bus.rd         = inst_q.rd;
    assign bus.rs1        = inst_q.rs1;
    assign bus.rs2        = inst_q.rs2;
    assign bus.imm        = inst_q.imm;
    assign bus.inst_pc    = ipc_q;

endmodule
